// File: rtl/matrix_ring_counter.sv
// matrix_ring_counter
// Column-group scanner for a multiplexed LED matrix. A prescaler divides the
// clock down to one column step every DIVIDER enabled cycles; a one-hot ring
// selects the active column group; a blank counter keeps the row drivers off
// for BLANK_CYCLES enabled cycles after each step so ghosting from the previous
// column has time to decay. Dropping enable freezes the scan and blanks the
// display.
//
// The ring register is the scanner's only state machine; its state is exposed
// directly on ring_counter. The output is masked so that a corrupted
// (non-one-hot) register never reaches the column decoder with more than one
// bit set. The corrupted value is replaced by the first column on the next edge.

module matrix_ring_counter #(
    parameter int DIVIDER      = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    output logic [2:0] ring_counter,
    output logic       blank,
    output logic       step,
    output logic       frame_start
);

    // ------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------
    localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    localparam logic [CW-1:0] COUNT_LAST = CW'(DIVIDER - 1);
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);

    // Ring states: one column group per bit, rotated left.
    localparam logic [2:0] RING_COL0 = 3'b001;
    localparam logic [2:0] RING_COL1 = 3'b010;
    localparam logic [2:0] RING_COL2 = 3'b100;

    // Reject parameter values that the counters cannot represent.
    if (DIVIDER < 2 || DIVIDER > (1 << 20)) begin : g_bad_divider
        $error("matrix_ring_counter: DIVIDER out of range 2..2^20");
    end
    if (BLANK_CYCLES < 0 || BLANK_CYCLES > DIVIDER - 1) begin : g_bad_blank
        $error("matrix_ring_counter: BLANK_CYCLES out of range 0..DIVIDER-1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0] count_q;
    logic [2:0]    ring_q;
    logic [BW-1:0] blank_cnt_q;
    logic          step_q;
    logic          frame_q;

    logic          ring_legal;
    logic          count_wrap;
    logic          rotate;
    logic [2:0]    ring_next;

    // Exactly one of the three legal one-hot codes.
    assign ring_legal = (ring_q == RING_COL0) ||
                        (ring_q == RING_COL1) ||
                        (ring_q == RING_COL2);

    assign count_wrap = (count_q == COUNT_LAST);

    // A column step happens only on an enabled wrap of a healthy ring; a
    // corrupted ring is repaired instead, and that repair is not a step.
    assign rotate = enable && count_wrap && ring_legal;

    // Rotate-left successor of the current column group.
    always_comb begin
        ring_next = RING_COL0;
        case (ring_q)
            RING_COL0: ring_next = RING_COL1;
            RING_COL1: ring_next = RING_COL2;
            RING_COL2: ring_next = RING_COL0;
            default:   ring_next = RING_COL0;
        endcase
    end

    // Prescaler: counts enabled cycles modulo DIVIDER, holds while disabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (enable) begin
            if (count_wrap) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // Column ring: repair corruption on any edge, otherwise rotate on a step.
    always_ff @(posedge clock) begin
        if (reset) begin
            ring_q <= RING_COL0;
        end else if (!ring_legal) begin
            ring_q <= RING_COL0;
        end else if (rotate) begin
            ring_q <= ring_next;
        end
    end

    // Blank counter: reload on every step (even mid-window), else run down.
    always_ff @(posedge clock) begin
        if (reset) begin
            blank_cnt_q <= BLANK_LOAD;
        end else if (rotate) begin
            blank_cnt_q <= BLANK_LOAD;
        end else if (enable && (blank_cnt_q != '0)) begin
            blank_cnt_q <= blank_cnt_q - 1'b1;
        end
    end

    // Step and frame pulses, registered alongside the ring they announce.
    always_ff @(posedge clock) begin
        if (reset) begin
            step_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            step_q  <= rotate;
            frame_q <= rotate && (ring_next == RING_COL0);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ring_counter = ring_legal ? ring_q : 3'b000;
    assign blank        = (blank_cnt_q != '0) || !enable;
    assign step         = step_q;
    assign frame_start  = frame_q;

endmodule

// File: tb/tb_matrix_ring_counter.sv
// tb_matrix_ring_counter
// Four instances with different DIVIDER/BLANK_CYCLES settings share one clock.
// Each cycle: inputs are set just after the rising edge, outputs are compared
// a moment later, then the next rising edge consumes the inputs.

module tb_matrix_ring_counter;

    // ------------------------------------------------------------------
    // Clock / reset block
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Instance A: DIVIDER=4, BLANK_CYCLES=1
    logic       rst_a, en_a, blank_a, step_a, frame_a;
    logic [2:0] ring_a;
    // Instance B: DIVIDER=4, BLANK_CYCLES=2
    logic       rst_b, en_b, blank_b, step_b, frame_b;
    logic [2:0] ring_b;
    // Instance C: DIVIDER=2, BLANK_CYCLES=1
    logic       rst_c, en_c, blank_c, step_c, frame_c;
    logic [2:0] ring_c;
    // Instance R: DIVIDER=5, BLANK_CYCLES=3 (random stimulus)
    logic       rst_r, en_r, blank_r, step_r, frame_r;
    logic [2:0] ring_r;

    matrix_ring_counter #(.DIVIDER(4), .BLANK_CYCLES(1)) u_a (
        .clock(clk), .reset(rst_a), .enable(en_a), .ring_counter(ring_a),
        .blank(blank_a), .step(step_a), .frame_start(frame_a)
    );
    matrix_ring_counter #(.DIVIDER(4), .BLANK_CYCLES(2)) u_b (
        .clock(clk), .reset(rst_b), .enable(en_b), .ring_counter(ring_b),
        .blank(blank_b), .step(step_b), .frame_start(frame_b)
    );
    matrix_ring_counter #(.DIVIDER(2), .BLANK_CYCLES(1)) u_c (
        .clock(clk), .reset(rst_c), .enable(en_c), .ring_counter(ring_c),
        .blank(blank_c), .step(step_c), .frame_start(frame_c)
    );
    matrix_ring_counter #(.DIVIDER(5), .BLANK_CYCLES(3)) u_r (
        .clock(clk), .reset(rst_r), .enable(en_r), .ring_counter(ring_r),
        .blank(blank_r), .step(step_r), .frame_start(frame_r)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters and compare helper
    // ------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    // Advance past the next rising edge; inputs may then be changed safely.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        en_a  = 1'b0;
        next_cycle();
        rst_a = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Vector table for the basic 13-cycle scan (DIVIDER=4, BLANK_CYCLES=1)
    // ------------------------------------------------------------------
    typedef struct {
        logic       en;
        logic [2:0] ring;
        logic       step;
        logic       frame;
        logic       blank;
    } vec_t;

    vec_t tbl[13];

    // Forced illegal ring pattern (module scope so force can reference it).
    logic [2:0] bad_pat;

    // Reference model for instance R: n counts enabled, non-reset edges.
    int  n_r;
    bit  step_m;

    initial begin
        int saved_cnt;
        logic prev_step;
        logic [2:0] exp_ring;
        logic do_rst, do_en;

        tbl[0]  = '{1'b1, 3'b001, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 3'b001, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 3'b001, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 3'b001, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 3'b010, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 3'b010, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 3'b010, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 3'b010, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 3'b100, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 3'b100, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 3'b100, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 3'b100, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 3'b001, 1'b1, 1'b1, 1'b1};

        rst_a = 1'b1; en_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0;
        rst_c = 1'b1; en_c = 1'b0;
        rst_r = 1'b1; en_r = 1'b0;
        bad_pat = 3'b000;
        next_cycle();
        next_cycle();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_r = 1'b0;

        // Reset state, display disabled.
        settle();
        check("rst_ring",  ring_a,     3'b001);
        check("rst_step",  step_a,     0);
        check("rst_frame", frame_a,    0);
        check("rst_blank", blank_a,    1);
        check("rst_count", u_a.count_q, 0);

        // Basic scan from the table.
        for (int i = 0; i < 13; i++) begin
            en_a = tbl[i].en;
            settle();
            check($sformatf("tbl%0d_ring", i),  ring_a,  tbl[i].ring);
            check($sformatf("tbl%0d_step", i),  step_a,  tbl[i].step);
            check($sformatf("tbl%0d_frame", i), frame_a, tbl[i].frame);
            check($sformatf("tbl%0d_blank", i), blank_a, tbl[i].blank);
            next_cycle();
        end

        // Freeze for 5 cycles with the prescaler at 2, then resume.
        reset_a();
        en_a = 1'b1;
        next_cycle();
        next_cycle();
        en_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            check($sformatf("frz%0d_ring", i),  ring_a,      3'b001);
            check($sformatf("frz%0d_count", i), u_a.count_q, 2);
            check($sformatf("frz%0d_blank", i), blank_a,     1);
            check($sformatf("frz%0d_step", i),  step_a,      0);
            next_cycle();
        end
        en_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            check($sformatf("resume%0d_step", k), step_a, (k == 2) ? 1 : 0);
            check($sformatf("resume%0d_ring", k), ring_a, (k == 2) ? 3'b010 : 3'b001);
            next_cycle();
        end

        // Reset landing on the rotation cycle.
        reset_a();
        en_a = 1'b1;
        for (int i = 0; i < 11; i++) next_cycle();
        settle();
        check("rotrst_pre_count", u_a.count_q, 3);
        check("rotrst_pre_ring",  ring_a,      3'b100);
        rst_a = 1'b1;
        next_cycle();
        rst_a = 1'b0;
        settle();
        check("rotrst_ring",  ring_a,      3'b001);
        check("rotrst_count", u_a.count_q, 0);
        check("rotrst_step",  step_a,      0);
        check("rotrst_frame", frame_a,     0);
        check("rotrst_blank", blank_a,     1);
        next_cycle();
        // One enabled edge since the reset: prescaler now 1.
        saved_cnt = 1;

        // Illegal ring values repaired while disabled.
        en_a = 1'b0;
        for (int p = 0; p < 2; p++) begin
            bad_pat = (p == 0) ? 3'b110 : 3'b000;
            force u_a.ring_q = bad_pat;
            #1;
            release u_a.ring_q;
            settle();
            check($sformatf("ill%0d_masked", p), ring_a, 3'b000);
            next_cycle();
            settle();
            check($sformatf("ill%0d_ring", p),  ring_a,      3'b001);
            check($sformatf("ill%0d_step", p),  step_a,      0);
            check($sformatf("ill%0d_frame", p), frame_a,     0);
            check($sformatf("ill%0d_count", p), u_a.count_q, saved_cnt);
            next_cycle();
        end

        // Blank window of two cycles (instance B).
        rst_b = 1'b1;
        next_cycle();
        rst_b = 1'b0;
        en_b  = 1'b1;
        for (int c = 0; c < 9; c++) begin
            settle();
            check($sformatf("b%0d_blank", c), blank_b, ((c % 4) < 2) ? 1 : 0);
            check($sformatf("b%0d_step", c),  step_b,  (c > 0 && (c % 4) == 0) ? 1 : 0);
            next_cycle();
        end
        en_b = 1'b0;

        // Minimum divider (instance C).
        rst_c = 1'b1;
        next_cycle();
        rst_c = 1'b0;
        en_c  = 1'b1;
        prev_step = 1'b0;
        for (int c = 0; c < 8; c++) begin
            settle();
            exp_ring = 3'(3'b001 << ((c / 2) % 3));
            check($sformatf("c%0d_ring", c),   ring_c,  exp_ring);
            check($sformatf("c%0d_blank", c),  blank_c, ((c % 2) == 0) ? 1 : 0);
            check($sformatf("c%0d_step", c),   step_c,  (c > 0 && (c % 2) == 0) ? 1 : 0);
            check($sformatf("c%0d_nodbl", c),  prev_step && step_c, 0);
            prev_step = step_c;
            next_cycle();
        end
        en_c = 1'b0;

        // Random enable/reset against the reference model (instance R).
        rst_r = 1'b1;
        next_cycle();
        rst_r = 1'b0;
        n_r = 0;
        step_m = 1'b0;
        for (int i = 0; i < 500; i++) begin
            do_rst = ($urandom_range(0, 60) == 0);
            do_en  = ($urandom_range(0, 3) != 0);
            rst_r = do_rst;
            en_r  = do_en;
            settle();
            exp_ring = 3'(3'b001 << ((n_r / 5) % 3));
            check("rnd_ring",  ring_r,  exp_ring);
            check("rnd_step",  step_r,  step_m);
            check("rnd_frame", frame_r, step_m && (exp_ring == 3'b001));
            check("rnd_blank", blank_r, (!do_en || ((n_r % 5) < 3)) ? 1 : 0);
            next_cycle();
            if (do_rst) begin
                n_r = 0;
                step_m = 1'b0;
            end else if (do_en) begin
                step_m = ((n_r % 5) == 4);
                n_r++;
            end else begin
                step_m = 1'b0;
            end
        end
        rst_r = 1'b0;
        en_r  = 1'b0;

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_ring_counter.md
MATRIX_RING_COUNTER -- requirements
Module: matrix_ring_counter

Interface
REQ-001 Parameter DIVIDER, default 50000; clock cycles per column step; legal range 2..2^20.
REQ-002 Parameter BLANK_CYCLES, default 4; blanking cycles after each step; legal range 0..DIVIDER-1.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  high = scan runs; low = scan frozen, display blanked.
REQ-006 ring_counter  output [2:0]  one-hot column-group select; feeds the 3x5 mirrored column decoder.
REQ-007 blank  output  1  high = downstream row drivers SHALL be off.
REQ-008 step  output  1  one-cycle pulse, high in the first cycle a new ring_counter value is presented.
REQ-009 frame_start  output  1  one-cycle pulse, high in the first cycle ring_counter becomes 3'b001.

Function
REQ-010 Prescaler: registered count, width ceil(log2(DIVIDER)), range 0..DIVIDER-1.
REQ-011 Enabled cycle with count != DIVIDER-1: count increments by 1; ring_counter holds.
REQ-012 Enabled cycle with count == DIVIDER-1: count wraps to 0; ring_counter rotates left (001->010->100->001).
REQ-013 A rotation occurs exactly once every DIVIDER enabled cycles.
REQ-014 step and frame_start are registered.
  - Both update on the same edge as ring_counter.
  - step = 1 for exactly one cycle per rotation.
  - frame_start = 1 only when the rotated value is 3'b001.
REQ-015 Blank counter:
  - loaded with BLANK_CYCLES on every rotation edge;
  - otherwise decremented on each enabled cycle while nonzero.
REQ-016 blank = (blank counter != 0) OR (enable == 0); purely combinational from registered state and enable.
REQ-017 With BLANK_CYCLES = 0, blank is asserted only while enable is low.
REQ-018 Blank window after a rotation covers exactly BLANK_CYCLES consecutive enabled cycles, starting with the step cycle.
REQ-019 enable low:
  - prescaler, ring_counter and blank counter hold their values;
  - step = 0 and frame_start = 0;
  - on re-enable, counting resumes from the held values with no lost or extra cycles.
REQ-020 Illegal-state recovery: if ring_counter is not one-hot (including 000), the next edge loads 3'b001, regardless of enable.
  - This load SHALL NOT assert step or frame_start.
  - The prescaler continues normally.
REQ-021 Blank priority: a rotation edge reloads the blank counter even if the previous window has not expired.
REQ-022 Nowhere SHALL ring_counter present more than one active bit, including during recovery and reset.

Reset
REQ-023 When reset is high at a rising edge, the following values SHALL be loaded:
  - ring_counter = 3'b001;
  - prescaler = 0;
  - blank counter = BLANK_CYCLES;
  - step = 0, frame_start = 0.
REQ-024 Reset overrides enable, rotation and recovery in the same cycle.
REQ-025 After reset, blank stays high for BLANK_CYCLES enabled cycles, then falls.
REQ-026 Reset asserted mid-blank or mid-count fully reinitialises state; no pulse is emitted on the reset edge.

Verification (DIVIDER=4, BLANK_CYCLES=1 unless stated)
REQ-027 Reset, then enable=1 for 13 cycles:
  - ring_counter sequence 001x4, 010x4, 100x4, 001;
  - step pulses at cycles 4, 8, 12;
  - frame_start only at cycle 12.
REQ-028 Blank timing, BLANK_CYCLES=2:
  - blank = 1 for cycles 0-1 after reset, and in the step cycle plus the following cycle;
  - blank = 0 otherwise while enabled.
REQ-029 enable low for 5 cycles starting when prescaler = 2:
  - ring_counter and prescaler hold;
  - blank = 1 and step = 0 throughout;
  - after re-enable, the next step occurs 2 enabled cycles later.
REQ-030 Force ring_counter to 3'b110 (and separately 3'b000) with enable=0:
  - next edge shows 001;
  - step = 0, frame_start = 0.
REQ-031 Reset asserted on the rotation cycle (prescaler = 3, ring = 100):
  - next value ring = 001, prescaler = 0;
  - step = 0, frame_start = 0, blank = 1.
REQ-032 DIVIDER=2, BLANK_CYCLES=1, enable=1:
  - ring rotates every 2 cycles;
  - blank alternates 1,0 each rotation;
  - step never held for 2 consecutive cycles.
